// File: rtl/control.sv
// Instruction decoder: turns a 32-bit instruction word into a registered 32-bit control word.
// Decode is purely combinational from the instruction and is registered once (one cycle of latency).
module control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] output_control
);

  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b000010;
  localparam logic [5:0] OP_STORE = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b110010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [31:0] NOP_WORD = 32'h0000_01C0;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       reg_dst;
  logic [2:0] alu_op;
  logic       valid;
  logic       illegal;
  logic [4:0] write_addr;
  logic [4:0] read_a;
  logic [4:0] read_b;
  logic [31:0] decoded;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];

  // Default is the illegal encoding; each recognised form overrides it completely.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    alu_op     = ALU_NONE;
    valid      = 1'b0;
    illegal    = 1'b1;
    write_addr = 5'd0;
    read_a     = 5'd0;
    read_b     = 5'd0;

    if (instruction == 32'd0) begin
      illegal = 1'b0;
    end else begin
      unique case (opcode)
        OP_RTYPE: begin
          illegal = 1'b0;
          case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_MUL:  alu_op = ALU_MUL;
            default: illegal = 1'b1;
          endcase
          if (!illegal) begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            valid      = 1'b1;
            write_addr = rd;
            read_a     = rs;
            read_b     = rt;
          end
        end
        OP_LOAD: begin
          illegal    = 1'b0;
          reg_write  = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
          alu_src    = 1'b1;
          alu_op     = ALU_ADD;
          valid      = 1'b1;
          write_addr = rt;
          read_a     = rs;
          read_b     = rt;
        end
        OP_STORE: begin
          illegal   = 1'b0;
          mem_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALU_ADD;
          valid     = 1'b1;
          read_a    = rs;
          read_b    = rt;
        end
        default: ;
      endcase
    end
  end

  assign decoded = {6'd0, read_b, read_a, write_addr, illegal, valid, alu_op,
                    reg_dst, alu_src, mem_to_reg, mem_write, mem_read, reg_write};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) output_control <= NOP_WORD;
    else        output_control <= decoded;
  end

endmodule

// File: tb/tb_control.sv
// Directed testbench for the instruction decoder; expected words are hand-computed from the field map.
module tb_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] output_control;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_01C0;
  localparam logic [31:0] ILL_WORD = 32'h0000_05C0;

  control dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instruction    (instruction),
    .output_control (output_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present an instruction on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] expected;
  } vec_t;

  vec_t vectors[$];
  vec_t stream[$];

  initial begin
    vectors = '{
      '{"load",        32'h08E1_0501, 32'h0027_0A1B},
      '{"mul",         32'h0401_22B2, 32'h0020_2321},
      '{"sub_shamt",   32'h0485_32A2, 32'h00A4_3261},
      '{"store",       32'h0CE6_08FF, 32'h00C7_0214},
      '{"illegal_op",  32'hFC00_0000, ILL_WORD},
      '{"illegal_fn",  32'h0422_1807, ILL_WORD},
      '{"op0_nonzero", 32'h0000_0001, ILL_WORD},
      '{"nop",         32'h0000_0000, NOP_WORD},
      '{"add",         32'h0422_1820, 32'h0041_1A21}
    };
    stream = '{
      '{"seq_load",  32'h08E1_0501, 32'h0027_0A1B},
      '{"seq_add",   32'h0422_1820, 32'h0041_1A21},
      '{"seq_or",    32'h04A6_3825, 32'h00C5_3AE1},
      '{"seq_and",   32'h04E8_4824, 32'h0107_4AA1},
      '{"seq_store", 32'h0CE6_08FF, 32'h00C7_0214}
    };

    rst_n       = 1'b1;
    instruction = 32'h08E1_0501;
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_async", output_control, NOP_WORD);
    @(posedge clk);
    #1 checkOutput("reset_held_edge", output_control, NOP_WORD);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("first_edge_after_reset", output_control, 32'h0027_0A1B);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].instr);
      checkOutput(vectors[i].tag, output_control, vectors[i].expected);
    end

    // Same instruction across two edges must leave the word unchanged.
    applyStimulus(32'h0CE6_08FF);
    @(posedge clk);
    #1 checkOutput("hold_store", output_control, 32'h00C7_0214);

    // Back-to-back stream: each word must show up exactly one edge after its instruction.
    foreach (stream[i]) begin
      @(negedge clk);
      checkOutput({stream[i].tag, "_before"}, output_control,
                  (i == 0) ? 32'h00C7_0214 : stream[i-1].expected);
      instruction = stream[i].instr;
      @(posedge clk);
      #1 checkOutput(stream[i].tag, output_control, stream[i].expected);
    end

    // Reset pulse between edges: NOP at once, decoding resumes on the next edge.
    @(negedge clk);
    instruction = 32'h04A6_3825;
    #1 rst_n = 1'b0;
    #1 checkOutput("midstream_reset", output_control, NOP_WORD);
    #1 rst_n = 1'b1;
    #1 checkOutput("reset_released_no_edge", output_control, NOP_WORD);
    @(posedge clk);
    #1 checkOutput("resume_or", output_control, 32'h00C5_3AE1);

    applyStimulus(32'h0485_32A2);
    checkOutput("resume_sub", output_control, 32'h00A4_3261);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish expected finish before 20000");
    $fatal(1, "[TB] timeout");
  end

endmodule
